// File: rtl/memory_access_cycle.sv
// memory_access_cycle: memory stage with load/store handshake, load lane conversion,
// misalignment detection and a busy timeout that latches an error state.
module memory_access_cycle (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] StoreCounterOutM,
    input  logic [31:0] PCPlusImmM,
    input  logic [5:0]  ALUSelectM,
    input  logic [4:0]  WriteAddressM,
    input  logic        JtypeM,
    input  logic        RegWriteM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic        BranchM,
    output logic        StallM,
    output logic [31:0] DMemAddress,
    output logic [31:0] DMemWriteData,
    output logic        DMemRead,
    output logic        DMemWrite,
    input  logic [31:0] DMemReadData,
    input  logic        DMemBusy,
    output logic [31:0] WBDataW,
    output logic [4:0]  WriteAddressW,
    output logic        RegWriteW,
    output logic        BranchTakenW,
    output logic [31:0] BranchTargetW,
    output logic        MisalignW,
    output logic        MemErrorW
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, ERROR = 2'd2;
    function automatic logic is_byte(input logic [2:0] sel);
        return sel == 3'b000 || sel == 3'b100;
    endfunction
    function automatic logic is_half(input logic [2:0] sel);
        return sel == 3'b001 || sel == 3'b101;
    endfunction
    function automatic logic misaligned(input logic [2:0] sel, input logic [1:0] a);
        return is_half(sel) ? a[0] : (!is_byte(sel) && a != 2'b00);
    endfunction
    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        s_valid_q, s_j_q, s_rw_q, s_mr_q, s_mw_q, s_br_q;
    logic [31:0] s_alu_q, s_store_q, s_pc_q;
    logic [5:0]  s_sel_q;
    logic [4:0]  s_wa_q;
    logic [31:0] wb_q, tgt_q;
    logic [4:0]  wa_q;
    logic        rw_q, bt_q, mis_q;
    logic        m_access, s_mis, upd, unused_sel;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] load_data;
    assign m_access = (MemReadM || MemWriteM) && !misaligned(ALUSelectM[2:0], ALUOutM[1:0]);
    assign s_mis = s_valid_q && (s_mr_q || s_mw_q) && misaligned(s_sel_q[2:0], s_alu_q[1:0]);
    assign StallM = (state_q == ACCESS && DMemBusy) || state_q == ERROR;
    assign upd = s_valid_q && !StallM;
    assign unused_sel = ^s_sel_q[5:3];
    assign ld_b = DMemReadData[{s_alu_q[1:0], 3'b000} +: 8];
    assign ld_h = s_alu_q[1] ? DMemReadData[31:16] : DMemReadData[15:0];
    assign load_data = is_byte(s_sel_q[2:0]) ? {{24{!s_sel_q[2] && ld_b[7]}}, ld_b}
                     : is_half(s_sel_q[2:0]) ? {{16{!s_sel_q[2] && ld_h[15]}}, ld_h}
                     : DMemReadData;
    assign DMemRead = state_q == ACCESS && s_mr_q;
    assign DMemWrite = state_q == ACCESS && s_mw_q;
    assign DMemAddress = s_alu_q;
    assign DMemWriteData = s_store_q;
    assign WBDataW = wb_q;
    assign WriteAddressW = wa_q;
    assign RegWriteW = rw_q;
    assign BranchTakenW = bt_q;
    assign BranchTargetW = tgt_q;
    assign MisalignW = mis_q;
    assign MemErrorW = err_q;
    // Counter restarts whenever a fresh access is loaded; ERROR is a trap state.
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == IDLE) begin
            state_d = m_access ? ACCESS : IDLE;
            cnt_d = 8'd0;
        end else if (state_q == ACCESS && DMemBusy) begin
            cnt_d = cnt_q + 8'd1;
            state_d = cnt_q == 8'd254 ? ERROR : ACCESS;
            err_d = err_q || cnt_q == 8'd254;
        end else if (state_q == ACCESS) begin
            state_d = m_access ? ACCESS : IDLE;
            cnt_d = 8'd0;
        end
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q <= 8'd0;
            err_q <= 1'b0;
            s_valid_q <= 1'b0;
            s_alu_q <= 32'd0;
            s_store_q <= 32'd0;
            s_pc_q <= 32'd0;
            s_sel_q <= 6'd0;
            s_wa_q <= 5'd0;
            {s_j_q, s_rw_q, s_mr_q, s_mw_q, s_br_q} <= 5'd0;
            wb_q <= 32'd0;
            tgt_q <= 32'd0;
            wa_q <= 5'd0;
            {rw_q, bt_q, mis_q} <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (!StallM) begin
                s_valid_q <= 1'b1;
                s_alu_q <= ALUOutM;
                s_store_q <= StoreCounterOutM;
                s_pc_q <= PCPlusImmM;
                s_sel_q <= ALUSelectM;
                s_wa_q <= WriteAddressM;
                {s_j_q, s_rw_q, s_mr_q, s_mw_q, s_br_q} <= {JtypeM, RegWriteM, MemReadM, MemWriteM, BranchM};
            end
            rw_q <= upd && s_rw_q && !s_mis;
            bt_q <= upd && (s_br_q || s_j_q);
            mis_q <= upd && s_mis;
            if (upd) begin
                wb_q <= s_mr_q ? load_data : s_alu_q;
                wa_q <= s_wa_q;
                tgt_q <= s_pc_q;
            end
        end
    end
endmodule

// File: tb/tb_memory_access_cycle.sv
// tb_memory_access_cycle: directed vectors; expected writebacks go into a scoreboard
// queue that a negedge monitor drains whenever the W stage presents a result.
module tb_memory_access_cycle;
    logic        CLK = 1'b0, RESET;
    logic [31:0] ALUOutM, StoreCounterOutM, PCPlusImmM, DMemReadData;
    logic [5:0]  ALUSelectM;
    logic [4:0]  WriteAddressM;
    logic        JtypeM, RegWriteM, MemReadM, MemWriteM, BranchM, DMemBusy;
    logic        StallM, DMemRead, DMemWrite, RegWriteW, BranchTakenW, MisalignW, MemErrorW;
    logic [31:0] DMemAddress, DMemWriteData, WBDataW, BranchTargetW;
    logic [4:0]  WriteAddressW;
    int checks = 0, failures = 0;
    typedef struct {
        logic [31:0] wb;
        logic [4:0]  wa;
        logic        rw, bt, mis, wb_care;
        logic [31:0] tgt;
    } exp_t;
    exp_t sb[$];
    memory_access_cycle dut (
        .CLK(CLK), .RESET(RESET), .ALUOutM(ALUOutM), .StoreCounterOutM(StoreCounterOutM),
        .PCPlusImmM(PCPlusImmM), .ALUSelectM(ALUSelectM), .WriteAddressM(WriteAddressM),
        .JtypeM(JtypeM), .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .BranchM(BranchM), .StallM(StallM), .DMemAddress(DMemAddress), .DMemWriteData(DMemWriteData),
        .DMemRead(DMemRead), .DMemWrite(DMemWrite), .DMemReadData(DMemReadData), .DMemBusy(DMemBusy),
        .WBDataW(WBDataW), .WriteAddressW(WriteAddressW), .RegWriteW(RegWriteW),
        .BranchTakenW(BranchTakenW), .BranchTargetW(BranchTargetW), .MisalignW(MisalignW),
        .MemErrorW(MemErrorW)
    );
    always #5 CLK = ~CLK;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp_v);
        end
    endtask
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    task automatic op(input logic [31:0] alu, st, pc, input logic [5:0] sel, input logic [4:0] wa,
                      input logic j, rw, mr, mw, br);
        ALUOutM = alu; StoreCounterOutM = st; PCPlusImmM = pc; ALUSelectM = sel; WriteAddressM = wa;
        JtypeM = j; RegWriteM = rw; MemReadM = mr; MemWriteM = mw; BranchM = br;
    endtask
    task automatic nop();
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic push(input logic [31:0] wb, input logic [4:0] wa, input logic rw, bt, mis, care,
                        input logic [31:0] tgt);
        exp_t e;
        e.wb = wb; e.wa = wa; e.rw = rw; e.bt = bt; e.mis = mis; e.wb_care = care; e.tgt = tgt;
        sb.push_back(e);
    endtask
    always @(negedge CLK) begin
        if (!RESET && (RegWriteW || MisalignW || BranchTakenW)) begin
            if (sb.size() == 0) chk("unexpected_w_update", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                if (e.wb_care) chk("sb_wbdata", WBDataW, e.wb);
                chk("sb_waddr", {27'd0, WriteAddressW}, {27'd0, e.wa});
                chk("sb_flags", {29'd0, RegWriteW, BranchTakenW, MisalignW}, {29'd0, e.rw, e.bt, e.mis});
                if (e.bt) chk("sb_target", BranchTargetW, e.tgt);
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
    initial begin
        RESET = 1'b1; DMemBusy = 1'b0; DMemReadData = 32'd0;
        nop();
        repeat (3) tick();
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_stall", {31'd0, StallM}, 32'd0);
        chk("rst_strobes", {30'd0, DMemRead, DMemWrite}, 32'd0);
        chk("rst_wb", WBDataW, 32'd0);
        chk("rst_flags", {28'd0, RegWriteW, BranchTakenW, MisalignW, MemErrorW}, 32'd0);
        // ADD: plain ALU result, one edge from capture to W
        tick();
        op(32'h10, 0, 0, 6'd0, 5'd5, 0, 1, 0, 0, 0);
        push(32'h10, 5'd5, 1, 0, 0, 1, 0);
        tick();
        nop();
        @(negedge CLK);
        chk("add_stall", {31'd0, StallM}, 32'd0);
        tick();
        @(negedge CLK);
        chk("add_stall2", {31'd0, StallM}, 32'd0);
        // LB / LBU from lane 3
        DMemReadData = 32'h80FF_0000;
        tick();
        op(32'h103, 0, 0, 6'b000000, 5'd7, 0, 1, 1, 0, 0);
        push(32'hFFFF_FF80, 5'd7, 1, 0, 0, 1, 0);
        tick();
        nop();
        @(negedge CLK);
        chk("lb_read", {31'd0, DMemRead}, 32'd1);
        chk("lb_addr", DMemAddress, 32'h103);
        chk("lb_stall", {31'd0, StallM}, 32'd0);
        tick();
        op(32'h103, 0, 0, 6'b000100, 5'd8, 0, 1, 1, 0, 0);
        push(32'h0000_0080, 5'd8, 1, 0, 0, 1, 0);
        tick();
        nop();
        tick();
        @(negedge CLK);
        chk("lbu_idle_strobe", {31'd0, DMemRead}, 32'd0);
        // SW with three busy cycles
        tick();
        op(32'h200, 32'hDEAD_BEEF, 0, 6'b000010, 5'd9, 0, 1, 0, 1, 0);
        push(32'h200, 5'd9, 1, 0, 0, 1, 0);
        DMemBusy = 1'b1;
        tick();
        nop();
        for (int i = 0; i < 4; i++) begin
            DMemBusy = i < 3;
            @(negedge CLK);
            chk("sw_write", {31'd0, DMemWrite}, 32'd1);
            chk("sw_addr", DMemAddress, 32'h200);
            chk("sw_data", DMemWriteData, 32'hDEAD_BEEF);
            chk("sw_stall", {31'd0, StallM}, {31'd0, i < 3});
            chk("sw_no_early_w", {31'd0, RegWriteW}, 32'd0);
            tick();
        end
        @(negedge CLK);
        chk("sw_done_write", {31'd0, DMemWrite}, 32'd0);
        // Misaligned LW, then aligned halfword loads
        DMemReadData = 32'hBEEF_1234;
        tick();
        op(32'h202, 0, 0, 6'b000010, 5'd3, 0, 1, 1, 0, 0);
        push(0, 5'd3, 0, 0, 1, 0, 0);
        tick();
        nop();
        @(negedge CLK);
        chk("mis_no_strobe", {30'd0, DMemRead, DMemWrite}, 32'd0);
        chk("mis_stall", {31'd0, StallM}, 32'd0);
        tick();
        tick();
        @(negedge CLK);
        chk("mis_pulse_end", {31'd0, MisalignW}, 32'd0);
        tick();
        op(32'h202, 0, 0, 6'b000001, 5'd10, 0, 1, 1, 0, 0);
        push(32'hFFFF_BEEF, 5'd10, 1, 0, 0, 1, 0);
        tick();
        nop();
        @(negedge CLK);
        chk("lh_read", {31'd0, DMemRead}, 32'd1);
        tick();
        op(32'h200, 0, 0, 6'b000101, 5'd11, 0, 1, 1, 0, 0);
        push(32'h0000_1234, 5'd11, 1, 0, 0, 1, 0);
        tick();
        nop();
        tick();
        // Back-to-back loads keep the FSM in ACCESS
        op(32'h204, 0, 0, 6'b000010, 5'd12, 0, 1, 1, 0, 0);
        push(32'hBEEF_1234, 5'd12, 1, 0, 0, 1, 0);
        tick();
        op(32'h101, 0, 0, 6'b000100, 5'd13, 0, 1, 1, 0, 0);
        push(32'h0000_0012, 5'd13, 1, 0, 0, 1, 0);
        tick();
        nop();
        @(negedge CLK);
        chk("b2b_read", {31'd0, DMemRead}, 32'd1);
        chk("b2b_addr", DMemAddress, 32'h101);
        tick();
        // Jump redirect
        op(32'h44, 0, 32'h1000, 6'd0, 5'd1, 1, 1, 0, 0, 0);
        push(32'h44, 5'd1, 1, 1, 0, 1, 32'h1000);
        tick();
        nop();
        tick();
        tick();
        // Reset during a busy LW discards it
        op(32'h300, 0, 0, 6'b000010, 5'd4, 0, 1, 1, 0, 0);
        DMemBusy = 1'b1;
        tick();
        nop();
        RESET = 1'b1;
        @(negedge CLK);
        chk("rstmid_read", {31'd0, DMemRead}, 32'd1);
        tick();
        RESET = 1'b0;
        DMemBusy = 1'b0;
        @(negedge CLK);
        chk("rstmid_drop", {30'd0, DMemRead, DMemWrite}, 32'd0);
        chk("rstmid_stall", {31'd0, StallM}, 32'd0);
        tick();
        tick();
        // Busy timeout into ERROR
        op(32'h400, 0, 0, 6'b000010, 5'd6, 0, 1, 1, 0, 0);
        DMemBusy = 1'b1;
        tick();
        nop();
        repeat (254) tick();
        @(negedge CLK);
        chk("to_254_err", {31'd0, MemErrorW}, 32'd0);
        chk("to_254_stall", {31'd0, StallM}, 32'd1);
        tick();
        @(negedge CLK);
        chk("to_255_err", {31'd0, MemErrorW}, 32'd1);
        chk("to_err_read", {31'd0, DMemRead}, 32'd0);
        DMemBusy = 1'b0;
        repeat (3) tick();
        @(negedge CLK);
        chk("err_stall", {31'd0, StallM}, 32'd1);
        chk("err_sticky", {31'd0, MemErrorW}, 32'd1);
        chk("err_regwrite", {31'd0, RegWriteW}, 32'd0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        chk("err_rst_flag", {31'd0, MemErrorW}, 32'd0);
        chk("err_rst_stall", {31'd0, StallM}, 32'd0);
        chk("err_rst_wb", WBDataW, 32'd0);
        repeat (3) tick();
        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory_access_cycle.md
MEMORY_ACCESS_CYCLE -- requirements
Module: memory_access_cycle

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named CLK and RESET.
REQ-002 The ports SHALL be as follows (clock and reset first):
- CLK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high reset
- ALUOutM  in  32  ALU result and memory address
- StoreCounterOutM  in  32  store data, already lane-aligned
- PCPlusImmM  in  32  branch/jump target
- ALUSelectM  in  6  op select; bits[2:0] give load width
- WriteAddressM  in  5  destination register
- JtypeM, RegWriteM, MemReadM, MemWriteM, BranchM  in  1 each  control
- StallM  out  1  holds the upstream stage
- DMemAddress  out  32  data-memory address
- DMemWriteData  out  32  data-memory write data
- DMemRead, DMemWrite  out  1 each  memory request strobes
- DMemReadData  in  32  memory read data
- DMemBusy  in  1  memory not ready
- WBDataW  out  32  writeback data
- WriteAddressW  out  5  writeback destination
- RegWriteW  out  1  writeback enable
- BranchTakenW  out  1  PC redirect
- BranchTargetW  out  32  redirect target
- MisalignW  out  1  one-cycle misaligned-access pulse
- MemErrorW  out  1  sticky timeout flag

Function
REQ-003 Stage register S SHALL capture all M inputs on each edge where StallM=0; S.valid SHALL be set to 1 on such an edge.
REQ-004 Load width SHALL be decoded from ALUSelectM[2:0] as follows: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; any other value SHALL be treated as LW.
REQ-005 Misalignment SHALL be defined as halfword with addr[0]=1, or word with addr[1:0]≠0.
REQ-006 A memory op in S SHALL be an access if S.valid=1, (MemRead or MemWrite)=1, and the address is aligned.
REQ-007 The FSM SHALL have three states: IDLE, ACCESS and ERROR.
REQ-008 FSM transitions SHALL be:
- IDLE→ACCESS when an access is loaded into S.
- ACCESS→IDLE on an edge where DMemBusy=0, unless a new access loads into S on that edge, in which case the FSM SHALL remain in ACCESS.
- ACCESS→ERROR when the busy counter reaches 255.
- ERROR SHALL be left only by RESET.
REQ-009 In ACCESS, DMemRead and DMemWrite SHALL equal S.MemRead and S.MemWrite; DMemAddress SHALL equal S.ALUOut; DMemWriteData SHALL equal S.StoreData.
REQ-010 Outside ACCESS, both strobes SHALL be 0.
REQ-011 StallM SHALL be asserted combinationally as (state==ACCESS and DMemBusy) or state==ERROR.
REQ-012 A transaction SHALL complete in the ACCESS cycle with DMemBusy=0; DMemReadData SHALL be sampled in that cycle.
REQ-013 An 8-bit busy counter SHALL clear on ACCESS entry and increment each ACCESS cycle with DMemBusy=1.
REQ-014 On reaching 255, the busy counter SHALL set MemErrorW and move the FSM to ERROR; in ERROR, RegWriteW SHALL be 0 and StallM SHALL be 1.
REQ-015 Load data conversion SHALL select the byte lane by addr[1:0] and the halfword lane by addr[1]. LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend; LW SHALL pass the word unchanged.
REQ-016 The W registers SHALL update on each edge where S.valid=1 and StallM=0:
- WBDataW = converted load data if S.MemRead, else S.ALUOut.
- WriteAddressW = S.WriteAddress.
- RegWriteW = S.RegWrite and not misaligned.
- BranchTakenW = S.Branch or S.Jtype.
- BranchTargetW = S.PCPlusImm.
REQ-017 Non-memory ops SHALL have 1-cycle latency from capture into S to the W outputs; memory ops SHALL have 1 + (number of busy cycles) cycles.
REQ-018 A misaligned memory op SHALL issue no strobe, pulse MisalignW for 1 cycle with the W update, and keep the FSM in IDLE.
REQ-019 When S.valid=0 or S.valid is cleared, RegWriteW, BranchTakenW and MisalignW SHALL be 0 on the next edge.
REQ-020 A store SHALL produce RegWriteW = S.RegWrite; no read data SHALL be used.

Reset
REQ-021 When RESET=1 on an edge, the following SHALL be set to 0 on that edge regardless of other inputs: S.valid, all S fields, all W outputs, MemErrorW, the busy counter. The FSM SHALL go to IDLE.
REQ-022 RESET asserted mid-ACCESS SHALL drop DMemRead and DMemWrite in the next cycle, and the pending transaction SHALL be discarded.
REQ-023 StallM SHALL be 0 in the cycle following reset.

Verification
REQ-024 ADD: ALUOutM=0x00000010, RegWriteM=1, WriteAddressM=5 → one edge later WBDataW=0x10, WriteAddressW=5, RegWriteW=1, StallM=0 throughout.
REQ-025 LB: addr 0x103, DMemBusy=0, DMemReadData=0x80FF_0000 → WBDataW=0xFFFFFF80. Same stimulus as LBU → WBDataW=0x00000080.
REQ-026 SW: addr 0x200, data 0xDEADBEEF, DMemBusy=1 for 3 cycles → StallM=1 for 3 cycles, DMemWrite=1 for 4 cycles with constant address and data; the W update follows the completing edge.
REQ-027 LW at addr 0x202 → no strobe, MisalignW=1 for one cycle, RegWriteW=0. LH at addr 0x202 → normal access.
REQ-028 DMemBusy held at 1 → MemErrorW=1 after 255 busy cycles, StallM stays 1, and RESET clears everything; RESET asserted during a 2-cycle-busy LW → strobes 0 next cycle, no W write.
